// File: rtl/alu_decoder_mdu.sv
// ALU control decoder (RV32I + SLTU) with a sequencer for an iterative RV32M multiply/divide unit.
// MDU ops hold the core through stall until the registered one-cycle mdu_done pulse.
module alu_decoder_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [6:0]      opcode,
    input  logic [1:0]      ALU_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [3:0]      ALU_ctrl,
    output logic            is_mdu,
    output logic            stall,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result
);

    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic [2:0]          op_q, op_d;
    logic                mdu_done_q, mdu_done_d;
    logic [XLEN-1:0]     mdu_result_q, mdu_result_d;

    logic                unused_opcode_bits;
    logic                a_signed, b_signed, sign_a, sign_b, neg_start;
    logic [XLEN-1:0]     a_mag, b_mag, special_val, div_sel, div_fin, mul_fin, finish_val;
    logic                div_zero, div_ovf, special;
    logic [XLEN:0]       mul_add, div_shift, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   mul_step, div_step, step_val, full;

    assign unused_opcode_bits = ^{opcode[6], opcode[4:0]};

    always_comb begin
        is_mdu   = ENABLE_M && (ALU_op == 2'b10) && opcode[5] && (funct7 == 7'b0000001);
        ALU_ctrl = ALU_ADD;
        if (!is_mdu) begin
            case (ALU_op)
                2'b01: ALU_ctrl = ALU_SUB;
                2'b10: begin
                    case (funct3)
                        3'b000:  ALU_ctrl = (opcode[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  ALU_ctrl = ALU_SLL;
                        3'b010:  ALU_ctrl = ALU_SLT;
                        3'b011:  ALU_ctrl = ALU_SLTU;
                        3'b100:  ALU_ctrl = ALU_XOR;
                        3'b101:  ALU_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  ALU_ctrl = ALU_OR;
                        default: ALU_ctrl = ALU_AND;
                    endcase
                end
                default: ALU_ctrl = ALU_ADD;
            endcase
        end
    end

    assign stall      = valid_in & is_mdu & ~mdu_done_q;
    assign mdu_done   = mdu_done_q;
    assign mdu_result = mdu_result_q;

    // Operands are reduced to magnitudes at start; the result sign is reapplied at the end.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        sign_a      = a_signed & rs1_val[XLEN-1];
        sign_b      = b_signed & rs2_val[XLEN-1];
        a_mag       = sign_a ? -rs1_val : rs1_val;
        b_mag       = sign_b ? -rs2_val : rs2_val;
        neg_start   = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero    = (rs2_val == '0);
        div_ovf     = ~funct3[0] & (rs1_val == MIN_NEG) & (rs2_val == '1);
        special     = funct3[2] & (div_zero | div_ovf);
        special_val = div_zero ? (funct3[1] ? rs1_val : '1) : (funct3[1] ? '0 : rs1_val);
    end

    // prod_q holds {accumulator, multiplier} for MUL* and {remainder, dividend/quotient} for DIV*.
    always_comb begin
        mul_add   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod_q[0]}} & opnd_q};
        mul_step  = {mul_add, prod_q[XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[XLEN];
        div_step  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], prod_q[XLEN-2:0], div_ge};
        step_val  = op_q[2] ? div_step : mul_step;

        full       = neg_q ? -step_val : step_val;
        mul_fin    = (op_q[1:0] == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        div_sel    = op_q[1] ? step_val[2*XLEN-1:XLEN] : step_val[XLEN-1:0];
        div_fin    = neg_q ? -div_sel : div_sel;
        finish_val = op_q[2] ? div_fin : mul_fin;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        prod_d       = prod_q;
        opnd_d       = opnd_q;
        neg_d        = neg_q;
        op_d         = op_q;
        mdu_done_d   = 1'b0;
        mdu_result_d = mdu_result_q;
        case (state_q)
            IDLE: begin
                if (valid_in && is_mdu) begin
                    op_d    = funct3;
                    neg_d   = neg_start;
                    count_d = '0;
                    if (special) begin
                        mdu_result_d = special_val;
                        mdu_done_d   = 1'b1;
                        state_d      = DONE;
                    end else begin
                        opnd_d  = funct3[2] ? b_mag : a_mag;
                        prod_d  = {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!valid_in) begin
                    state_d = IDLE;
                end else begin
                    prod_d  = step_val;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        mdu_result_d = finish_val;
                        mdu_done_d   = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            prod_q       <= '0;
            opnd_q       <= '0;
            neg_q        <= 1'b0;
            op_q         <= '0;
            mdu_done_q   <= 1'b0;
            mdu_result_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prod_q       <= prod_d;
            opnd_q       <= opnd_d;
            neg_q        <= neg_d;
            op_q         <= op_d;
            mdu_done_q   <= mdu_done_d;
            mdu_result_q <= mdu_result_d;
        end
    end

endmodule

// File: tb/tb_alu_decoder_mdu.sv
// Bench for alu_decoder_mdu: arithmetic reference model checked every cycle, directed
// literal cases for decode, MDU results, latency, flush and reset abort, then random traffic.
module tb_alu_decoder_mdu;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic [6:0]      opcode;
    logic [1:0]      ALU_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [3:0]      ALU_ctrl;
    logic            is_mdu;
    logic            stall;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    int nvec = 0;
    int nerr = 0;

    alu_decoder_mdu #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .ALU_op(ALU_op),
        .funct7(funct7), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .ALU_ctrl(ALU_ctrl), .is_mdu(is_mdu), .stall(stall), .mdu_done(mdu_done),
        .mdu_result(mdu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_is(input logic [1:0] aop, input logic [6:0] opc, input logic [6:0] f7);
        return (aop == 2'b10) && opc[5] && (f7 == 7'd1);
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [1:0] aop, input logic [6:0] opc,
                                            input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] tbl [0:7];
        logic [3:0] r;
        tbl = '{4'h2, 4'h3, 4'h7, 4'h9, 4'h8, 4'h4, 4'h1, 4'h0};
        if (aop == 2'b01) r = 4'h6;
        else if (aop != 2'b10 || ref_is(aop, opc, f7)) r = 4'h2;
        else begin
            r = tbl[f3];
            if (f3 == 3'd0 && opc[5] && f7[5]) r = 4'h6;
            if (f3 == 3'd5 && f7[5]) r = 4'h5;
        end
        return r;
    endfunction

    function automatic logic ref_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] pu;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        pu  = 64'd0;
        r   = 32'd0;
        case (f3)
            3'd0: begin p = sa * sb; pu = p; r = pu[31:0]; end
            3'd1: begin p = sa * sb; pu = p; r = pu[63:32]; end
            3'd2: begin p = sa * longint'(b); pu = p; r = pu[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; pu = p; r = pu[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; pu = p; r = pu[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Reference model: remaining busy cycles, pending value, expected done/result for the next cycle.
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = '0;
    bit          armed  = 1'b0;

    initial begin
        logic       e_is;
        logic [3:0] e_ctrl;
        forever begin
            @(negedge clk);
            e_is   = ref_is(ALU_op, opcode, funct7);
            e_ctrl = ref_ctrl(ALU_op, opcode, funct7, funct3);
            if (armed) begin
                chk("alu_ctrl",   32'(ALU_ctrl),   32'(e_ctrl));
                chk("is_mdu",     32'(is_mdu),     32'(e_is));
                chk("stall",      32'(stall),      32'(valid_in & e_is & ~m_done));
                chk("mdu_done",   32'(mdu_done),   32'(m_done));
                chk("mdu_result", mdu_result,      m_res);
            end
            if (!rst_n) begin
                m_left = 0;
                m_done = 1'b0;
                m_res  = '0;
                armed  = 1'b1;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_left > 0) begin
                if (!valid_in) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        m_res  = m_pend;
                    end
                end
            end else if (valid_in && e_is) begin
                if (ref_special(funct3, rs1_val, rs2_val)) begin
                    m_done = 1'b1;
                    m_res  = mdu_ref(funct3, rs1_val, rs2_val);
                end else begin
                    m_left = XLEN;
                    m_pend = mdu_ref(funct3, rs1_val, rs2_val);
                end
            end
        end
    end

    task automatic set_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        opcode   = 7'h33;
        ALU_op   = 2'b10;
        funct7   = 7'h01;
        funct3   = f3;
        rs1_val  = a;
        rs2_val  = b;
        valid_in = 1'b1;
    endtask

    task automatic run_mdu(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat, input int exp_stall, input bit hold);
        int lat = 0;
        int st  = 0;
        bit got = 1'b0;
        set_mdu(f3, a, b);
        #1;
        if (stall) st++;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mdu_done) got = 1'b1;
            else if (stall) st++;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_result"}, mdu_result, exp_res);
        chk({nm, "_stall_at_done"}, 32'(stall), 32'd0);
        chk({nm, "_stall_cycles"}, st, exp_stall);
        if (!hold) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        opcode   = 7'h33;
        ALU_op   = 2'b00;
        funct7   = 7'h00;
        funct3   = 3'd0;
        rs1_val  = '0;
        rs2_val  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done",   32'(mdu_done), 32'd0);
        chk("reset_result", mdu_result,    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        ALU_op = 2'b10; funct7 = 7'h20;
        funct3 = 3'b000; #1 chk("dec_sub",  32'(ALU_ctrl), 32'h6);
        funct3 = 3'b101; #1 chk("dec_sra",  32'(ALU_ctrl), 32'h5);
        funct3 = 3'b011; #1 chk("dec_sltu", 32'(ALU_ctrl), 32'h9);
        ALU_op = 2'b01;  #1 chk("dec_op01", 32'(ALU_ctrl), 32'h6);
        ALU_op = 2'b11;  #1 chk("dec_op11", 32'(ALU_ctrl), 32'h2);
        ALU_op = 2'b10; funct7 = 7'h01; funct3 = 3'b100;
        #1 chk("dec_mdu_ctrl", 32'(ALU_ctrl), 32'h2);
        chk("dec_mdu_flag", 32'(is_mdu), 32'd1);
        @(posedge clk);
        #1;

        run_mdu("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33, 1'b0);
        run_mdu("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 33, 1'b0);
        run_mdu("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33, 1'b0);
        run_mdu("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 33, 1'b0);
        run_mdu("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1, 1'b0);
        run_mdu("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1, 1, 1'b0);
        run_mdu("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 1'b0);
        run_mdu("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1, 1'b0);
        run_mdu("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 33, 1'b0);
        run_mdu("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 33, 1'b0);
        run_mdu("mul_b2b",  3'd0, 32'd3,   32'd5, 32'd15, 33, 33, 1'b1);
        run_mdu("divu_b2b", 3'd5, 32'd100, 32'd7, 32'd14, 34, 33, 1'b0);

        set_mdu(3'd4, 32'd1000, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        valid_in = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (mdu_done) seen = 1'b1; end
        chk("flush_no_done",     32'(seen),  32'd0);
        chk("flush_result_held", mdu_result, 32'd14);

        set_mdu(3'd0, 32'd9, 32'd9);
        repeat (5) begin @(posedge clk); #1; end
        rst_n    = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_done",   32'(mdu_done), 32'd0);
        chk("abort_result", mdu_result,    32'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (mdu_done) seen = 1'b1; end
        chk("abort_no_done", 32'(seen), 32'd0);

        for (int n = 0; n < 300; n++) begin
            valid_in = 1'($urandom_range(0, 1));
            ALU_op   = 2'($urandom);
            opcode   = 7'($urandom);
            funct7   = ($urandom_range(0, 3) == 0) ? 7'h01 : 7'($urandom);
            funct3   = 3'($urandom);
            rs1_val  = pick();
            rs2_val  = pick();
            rst_n    = ($urandom_range(0, 49) != 0);
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        valid_in = 1'b0;
        repeat (40) begin @(posedge clk); #1; end

        for (int n = 0; n < 40; n++) begin
            set_mdu(3'($urandom_range(0, 7)), pick(), pick());
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (mdu_done) seen = 1'b1;
            end
            chk("rand_done_seen", 32'(seen), 32'd1);
        end
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
